// File: rtl/alu_result_collector.sv
// Collects completed ALU operations into {err, op_idx, result} records and queues them in a FIFO.
// Optional: define ALU_COLLECT_PARITY_EN to store and present an even-parity bit per record.
module alu_result_collector #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    alu_out,
  input  logic [1:0]    alu_state,
  input  logic [6:0]    alu_op,
  input  logic [2:0]    alu_in_sel,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [11:0]   rd_data,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [CW-1:0] err_cnt,
`ifdef ALU_COLLECT_PARITY_EN
  output logic [CW-1:0] op_cnt,
  output logic          rd_parity
`else
  output logic [CW-1:0] op_cnt
`endif
);

`ifdef ALU_COLLECT_PARITY_EN
  localparam int unsigned EW = 13;
`else
  localparam int unsigned EW = 12;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] last_entry;
  logic [EW-1:0] cur_entry;
  logic [EW-1:0] new_entry;
  logic [AW:0]   wr_cnt;
  logic [AW:0]   rd_cnt;
  logic [1:0]    prev_state;
  logic [7:0]    hold_res;
  logic [6:0]    hold_op;
  logic          seen_err;
  logic [2:0]    n_ones;
  logic [2:0]    op_idx;
  logic          bad_op;
  logic [11:0]   record;
  logic          empty;
  logic          flush;
  logic          complete;
  logic          do_pop;
  logic          do_push;

  // Decode the held one-hot op into a bit index; anything else is flagged bad.
  always_comb begin
    n_ones = 3'd0;
    op_idx = 3'd7;
    for (int i = 0; i < 7; i++) begin
      if (hold_op[i]) begin
        n_ones = n_ones + 3'd1;
        op_idx = 3'(i);
      end
    end
    bad_op = (n_ones != 3'd1);
    if (bad_op) op_idx = 3'd7;
  end

  assign record   = {seen_err | bad_op, op_idx, hold_res};
`ifdef ALU_COLLECT_PARITY_EN
  assign new_entry = {^record, record};
  assign rd_parity = cur_entry[12];
`else
  assign new_entry = record;
`endif

  assign level    = wr_cnt - rd_cnt;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign rd_valid = !empty;
  assign flush    = (alu_in_sel == 3'b100);
  assign complete = prev_state[1] & ~alu_state[1];
  assign do_pop   = !empty & rd_ready;
  assign do_push  = complete & (!full | do_pop);

  // Head entry while occupied; the last presented value while empty.
  assign cur_entry = empty ? last_entry : mem[rd_cnt[AW-1:0]];
  assign rd_data   = cur_entry[11:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_entry <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      prev_state <= 2'b00;
      hold_res   <= '0;
      hold_op    <= '0;
      seen_err   <= 1'b0;
      overflow   <= 1'b0;
      err_cnt    <= '0;
      op_cnt     <= '0;
    end else begin
      prev_state <= alu_state;
      last_entry <= cur_entry;
      if (alu_state[1]) begin
        hold_res <= alu_out;
        hold_op  <= alu_op;
      end
      if (flush) begin
        wr_cnt   <= '0;
        rd_cnt   <= '0;
        overflow <= 1'b0;
        seen_err <= 1'b0;
        err_cnt  <= '0;
        op_cnt   <= '0;
      end else begin
        if (complete)                seen_err <= 1'b0;
        else if (alu_state == 2'b11) seen_err <= 1'b1;
        if (do_pop) rd_cnt <= rd_cnt + (AW+1)'(1);
        if (do_push) begin
          mem[wr_cnt[AW-1:0]] <= new_entry;
          wr_cnt <= wr_cnt + (AW+1)'(1);
          op_cnt <= op_cnt + CW'(1);
          if (record[11] && err_cnt != '1) err_cnt <= err_cnt + CW'(1);
        end else if (complete) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
